// File: rtl/req_arb_n_1_credit.sv
`default_nettype none
// ============================================================================
//  Module      : req_arb_n_1_credit
//  Description : N:1 round-robin request arbiter with per-source credit
//                limiting of outstanding requests. A single registered output
//                stage carries the winning descriptor and its source tag.
//                Completions return one credit to the source named by cpl_id.
//  Ports       : aclk, aresetn        clock, asynchronous active-low reset
//                s_req_valid/ready    per-source request handshake
//                s_req_data           per-source descriptor, source i at
//                                     [i*DATA_BITS +: DATA_BITS]
//                m_req_valid/ready    arbitrated request handshake
//                m_req_data, m_req_id arbitrated descriptor and source index
//                cpl_valid, cpl_id    completion pulse returning one credit
//                err_cpl              sticky completion error flag
//                stat_grant, stat_stall  (REQ_ARB_STATS_EN only) saturating
//                                     per-source grant and stall counters
//  Config      : define REQ_ARB_STATS_EN to add the statistics counters/ports.
//  Revision    : 1.0  initial release
// ============================================================================
module req_arb_n_1_credit #(
    parameter int N_SRC     = 4,
    parameter int DATA_BITS = 96,
    parameter int MAX_OUT   = 8
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [N_SRC-1:0]           s_req_valid,
    output logic [N_SRC-1:0]           s_req_ready,
    input  logic [N_SRC*DATA_BITS-1:0] s_req_data,
    output logic                       m_req_valid,
    input  logic                       m_req_ready,
    output logic [DATA_BITS-1:0]       m_req_data,
    output logic [$clog2(N_SRC)-1:0]   m_req_id,
    input  logic                       cpl_valid,
    input  logic [$clog2(N_SRC)-1:0]   cpl_id,
    output logic                       err_cpl
`ifdef REQ_ARB_STATS_EN
    ,
    output logic [N_SRC*32-1:0]        stat_grant,
    output logic [31:0]                stat_stall
`endif
);

    localparam int ID_W  = $clog2(N_SRC);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] C_MAX_OUT = CNT_W'(MAX_OUT);
    localparam logic [ID_W-1:0]  C_LAST_RST = ID_W'(N_SRC - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 m_valid_q, m_valid_d;
    logic [DATA_BITS-1:0] m_data_q,  m_data_d;
    logic [ID_W-1:0]      m_id_q,    m_id_d;
    logic [ID_W-1:0]      last_q,    last_d;
    logic [CNT_W-1:0]     cnt_q [N_SRC];
    logic [CNT_W-1:0]     cnt_d [N_SRC];
    logic                 err_q,     err_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [N_SRC-1:0]     w_elig;
    logic                 w_any;
    logic                 w_found;
    int                   w_idx;
    logic [ID_W-1:0]      w_gnt_id;
    logic [DATA_BITS-1:0] w_gnt_data;
    logic                 w_load;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            w_elig[i] = s_req_valid[i] && (cnt_q[i] < C_MAX_OUT);
        end
        w_any = |w_elig;

        // Scan last+1, last+2, ... with wrap; the first eligible index wins,
        // so the source granted last has the lowest priority next time.
        w_found  = 1'b0;
        w_idx    = 0;
        w_gnt_id = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            w_idx = int'(last_q) + k;
            if (w_idx >= N_SRC) begin
                w_idx = w_idx - N_SRC;
            end
            if (!w_found && w_elig[ID_W'(w_idx)]) begin
                w_found  = 1'b1;
                w_gnt_id = ID_W'(w_idx);
            end
        end

        w_gnt_data = s_req_data[int'(w_gnt_id)*DATA_BITS +: DATA_BITS];

        // Accept only when the output register is empty or draining this cycle.
        w_load = w_any && (!m_valid_q || m_req_ready);

        for (int i = 0; i < N_SRC; i++) begin
            s_req_ready[i] = w_load && (w_gnt_id == ID_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Output stage, rotation pointer, credits, error flag
    // ------------------------------------------------------------------
    logic w_cpl_in_range;
    logic w_cpl_zero;
    logic w_inc;
    logic w_dec;

    always_comb begin
        m_valid_d = w_load || (m_valid_q && !m_req_ready);
        m_data_d  = w_load ? w_gnt_data : m_data_q;
        m_id_d    = w_load ? w_gnt_id   : m_id_q;
        last_d    = w_load ? w_gnt_id   : last_q;

        w_cpl_in_range = (int'(cpl_id) < N_SRC);
        w_cpl_zero     = 1'b0;
        w_inc          = 1'b0;
        w_dec          = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            w_inc = w_load && (w_gnt_id == ID_W'(i));
            w_dec = cpl_valid && w_cpl_in_range && (cpl_id == ID_W'(i))
                    && (cnt_q[i] != '0);
            if (cpl_valid && w_cpl_in_range && (cpl_id == ID_W'(i))
                && (cnt_q[i] == '0)) begin
                w_cpl_zero = 1'b1;
            end
            cnt_d[i] = cnt_q[i];
            if (w_inc && !w_dec) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (w_dec && !w_inc) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end

        err_d = err_q || (cpl_valid && !w_cpl_in_range) || w_cpl_zero;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_id_q    <= '0;
            last_q    <= C_LAST_RST;
            err_q     <= 1'b0;
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_id_q    <= m_id_d;
            last_q    <= last_d;
            err_q     <= err_d;
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign m_req_valid = m_valid_q;
    assign m_req_data  = m_data_q;
    assign m_req_id    = m_id_q;
    assign err_cpl     = err_q;

`ifdef REQ_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics
    // ------------------------------------------------------------------
    logic [31:0] stat_grant_q [N_SRC];
    logic [31:0] stat_grant_d [N_SRC];
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            stat_grant_d[i] = stat_grant_q[i];
            if (w_load && (w_gnt_id == ID_W'(i)) && (stat_grant_q[i] != 32'hFFFF_FFFF)) begin
                stat_grant_d[i] = stat_grant_q[i] + 32'd1;
            end
            stat_grant[i*32 +: 32] = stat_grant_q[i];
        end
        stat_stall_d = stat_stall_q;
        if (m_valid_q && !m_req_ready && (stat_stall_q != 32'hFFFF_FFFF)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_stall_q <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                stat_grant_q[i] <= '0;
            end
        end else begin
            stat_stall_q <= stat_stall_d;
            for (int i = 0; i < N_SRC; i++) begin
                stat_grant_q[i] <= stat_grant_d[i];
            end
        end
    end

    assign stat_stall = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_req_arb_n_1_credit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_arb_n_1_credit
//  Description : Directed self-checking bench for req_arb_n_1_credit.
//                Main instance N_SRC=4, MAX_OUT=8; a second N_SRC=3 instance
//                exercises an out-of-range completion id.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_req_arb_n_1_credit;

    localparam int DW = 16;

    logic            aclk;
    logic            aresetn;
    logic [3:0]      s_req_valid;
    logic [3:0]      s_req_ready;
    logic [4*DW-1:0] s_req_data;
    logic            m_req_valid;
    logic            m_req_ready;
    logic [DW-1:0]   m_req_data;
    logic [1:0]      m_req_id;
    logic            cpl_valid;
    logic [1:0]      cpl_id;
    logic            err_cpl;

    logic [2:0]      b_s_req_valid;
    logic [2:0]      b_s_req_ready;
    logic [3*DW-1:0] b_s_req_data;
    logic            b_m_req_valid;
    logic            b_m_req_ready;
    logic [DW-1:0]   b_m_req_data;
    logic [1:0]      b_m_req_id;
    logic            b_cpl_valid;
    logic [1:0]      b_cpl_id;
    logic            b_err_cpl;

    int n_chk;
    int n_err;

    req_arb_n_1_credit #(.N_SRC(4), .DATA_BITS(DW), .MAX_OUT(8)) u_dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_data  (s_req_data),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_data  (m_req_data),
        .m_req_id    (m_req_id),
        .cpl_valid   (cpl_valid),
        .cpl_id      (cpl_id),
        .err_cpl     (err_cpl)
    );

    req_arb_n_1_credit #(.N_SRC(3), .DATA_BITS(DW), .MAX_OUT(8)) u_dut3 (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_req_valid (b_s_req_valid),
        .s_req_ready (b_s_req_ready),
        .s_req_data  (b_s_req_data),
        .m_req_valid (b_m_req_valid),
        .m_req_ready (b_m_req_ready),
        .m_req_data  (b_m_req_data),
        .m_req_id    (b_m_req_id),
        .cpl_valid   (b_cpl_valid),
        .cpl_id      (b_cpl_id),
        .err_cpl     (b_err_cpl)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [DW-1:0] dval(input int i);
        return 16'hA5C0 ^ DW'(i * 16'h1111);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        aresetn       = 1'b0;
        s_req_valid   = '0;
        m_req_ready   = 1'b0;
        cpl_valid     = 1'b0;
        cpl_id        = '0;
        b_s_req_valid = '0;
        b_m_req_ready = 1'b1;
        b_cpl_valid   = 1'b0;
        b_cpl_id      = '0;
        b_s_req_data  = '0;
        for (int i = 0; i < 4; i++) s_req_data[i*DW +: DW] = dval(i);

        // ---------------- reset state
        step();
        step();
        chk("rst_vld",  m_req_valid, 0);
        chk("rst_data", m_req_data, 0);
        chk("rst_id",   m_req_id, 0);
        chk("rst_err",  err_cpl, 0);
        chk("rst_rdy",  s_req_ready, 0);
        chk("rst_err3", b_err_cpl, 0);
        aresetn = 1'b1;

        // ---------------- 1: all valid, completions every cycle
        s_req_valid = 4'hF;
        m_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cpl_valid = (k > 0);
            cpl_id    = 2'((k + 3) % 4);
            #2;
            chk("t1_rdy", s_req_ready, 64'(4'b0001 << (k % 4)));
            step();
            chk("t1_vld",  m_req_valid, 1);
            chk("t1_id",   m_req_id, 64'(k % 4));
            chk("t1_data", m_req_data, dval(k % 4));
        end
        s_req_valid = '0;
        cpl_valid   = 1'b1;
        cpl_id      = 2'd3;
        step();
        cpl_valid = 1'b0;
        chk("t1_idle", m_req_valid, 0);
        chk("t1_err",  err_cpl, 0);

        // ---------------- 2: only src2, credit exhaustion at 8
        s_req_valid = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            #2;
            chk("t2_rdy", s_req_ready, 4'b0100);
            step();
            chk("t2_vld", m_req_valid, 1);
            chk("t2_id",  m_req_id, 2);
        end
        #2;
        chk("t2_full_rdy", s_req_ready, 0);
        step();
        chk("t2_full_vld", m_req_valid, 0);
        cpl_valid = 1'b1;
        cpl_id    = 2'd2;
        #2;
        chk("t2_cpl_rdy", s_req_ready, 0);
        step();
        cpl_valid = 1'b0;
        #2;
        chk("t2_ninth_rdy", s_req_ready, 4'b0100);
        step();
        chk("t2_ninth_vld", m_req_valid, 1);
        chk("t2_ninth_id",  m_req_id, 2);
        s_req_valid = '0;
        cpl_valid   = 1'b1;
        cpl_id      = 2'd2;
        repeat (8) step();
        cpl_valid = 1'b0;
        chk("t2_err", err_cpl, 0);

        // ---------------- 3: stall with src1,src3 valid (pointer at 2)
        m_req_ready = 1'b0;
        s_req_valid = 4'b1010;
        #2;
        chk("t3_first_rdy", s_req_ready, 4'b1000);
        step();
        chk("t3_first_vld", m_req_valid, 1);
        chk("t3_first_id",  m_req_id, 3);
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("t3_stall_rdy", s_req_ready, 0);
            step();
            chk("t3_stall_vld",  m_req_valid, 1);
            chk("t3_stall_id",   m_req_id, 3);
            chk("t3_stall_data", m_req_data, dval(3));
        end
        m_req_ready = 1'b1;
        #2;
        chk("t3_rel_rdy1", s_req_ready, 4'b0010);
        step();
        chk("t3_rel_id1", m_req_id, 1);
        chk("t3_rel_data1", m_req_data, dval(1));
        #2;
        chk("t3_rel_rdy2", s_req_ready, 4'b1000);
        step();
        chk("t3_rel_id2", m_req_id, 3);
        s_req_valid = '0;
        step();
        chk("t3_idle", m_req_valid, 0);
        cpl_valid = 1'b1;
        cpl_id    = 2'd3;
        step();
        step();
        cpl_id    = 2'd1;
        step();
        cpl_valid = 1'b0;

        // ---------------- 4: grant + completion for src0 at cnt 3
        s_req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("t4_fill_rdy", s_req_ready, 4'b0001);
            step();
        end
        cpl_valid = 1'b1;
        cpl_id    = 2'd0;
        #2;
        chk("t4_same_rdy", s_req_ready, 4'b0001);
        step();
        cpl_valid = 1'b0;
        // cnt[0] must still be 3: exactly five more grants fit under MAX_OUT=8
        for (int k = 0; k < 6; k++) begin
            #2;
            chk("t4_rest_rdy", s_req_ready, (k < 5) ? 64'd1 : 64'd0);
            step();
        end
        chk("t4_idle", m_req_valid, 0);
        s_req_valid = '0;

        // ---------------- 5: completion errors
        chk("t5_err_pre",  err_cpl, 0);
        chk("t5_err3_pre", b_err_cpl, 0);
        cpl_valid   = 1'b1;
        cpl_id      = 2'd1;
        b_cpl_valid = 1'b1;
        b_cpl_id    = 2'd3;
        step();
        cpl_valid   = 1'b0;
        b_cpl_valid = 1'b0;
        chk("t5_err",  err_cpl, 1);
        chk("t5_err3", b_err_cpl, 1);
        step();
        step();
        chk("t5_sticky",  err_cpl, 1);
        chk("t5_sticky3", b_err_cpl, 1);
        s_req_valid = 4'b0010;
        #2;
        chk("t5_cnt1_rdy", s_req_ready, 4'b0010);
        step();
        chk("t5_cnt1_id", m_req_id, 1);
        s_req_valid = '0;

        // ---------------- 6: reset mid-burst
        s_req_valid = 4'hF;
        step();
        step();
        chk("t6_pre_vld", m_req_valid, 1);
        aresetn = 1'b0;
        #1;
        chk("t6_async_vld",  m_req_valid, 0);
        chk("t6_async_data", m_req_data, 0);
        chk("t6_async_id",   m_req_id, 0);
        chk("t6_async_err",  err_cpl, 0);
        chk("t6_async_err3", b_err_cpl, 0);
        step();
        aresetn = 1'b1;
        #2;
        chk("t6_rel_rdy", s_req_ready, 4'b0001);
        step();
        chk("t6_rel_vld", m_req_valid, 1);
        chk("t6_rel_id",  m_req_id, 0);
        chk("t6_rel_data", m_req_data, dval(0));
        s_req_valid = '0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
